// File: rtl/ddr3_frame_writer.sv
// ddr3_frame_writer: stages a host word stream in a small FIFO and writes it to
// DDR3 through the EMIF Avalon-MM port as fixed-length burst writes.
module ddr3_frame_writer #(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 2 * BURST_LEN
) (
    input  logic         mem_clk,
    input  logic         mem_rst,
    input  logic         start_in,
    input  logic [21:0]  start_addr_in,
    input  logic [31:0]  to_write_word_in,
    output logic         busy_out,
    output logic         write_done_out,
    input  logic [255:0] wr_data_in,
    input  logic         wr_data_valid_in,
    output logic         wr_ready_out,
    input  logic         ddr3_emif_ready,
    output logic         ddr3_emif_write,
    output logic         ddr3_emif_read,
    output logic [21:0]  ddr3_emif_addr,
    output logic [255:0] ddr3_emif_write_data,
    output logic [31:0]  ddr3_emif_byte_enable,
    output logic [4:0]   ddr3_emif_burst_count
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] LP_BURST = 32'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BURST,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [21:0]    r_addr;
    logic [31:0]    r_words_left;
    logic [31:0]    r_words_to_accept;
    logic           r_busy;
    logic           r_done;
    logic           r_write;
    logic [21:0]    r_emif_addr;
    logic [4:0]     r_burst_cnt;
    logic [4:0]     r_beat;

    logic [255:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;

    logic [AW:0]    w_count;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic [4:0]     w_blen;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_count == LP_DEPTH);
    assign wr_ready_out = r_busy && !w_full && (r_words_to_accept != 32'd0);
    assign w_push       = wr_data_valid_in && wr_ready_out;
    assign w_pop        = r_write && ddr3_emif_ready;
    assign w_blen       = (r_words_left >= LP_BURST) ? LP_BURST[4:0] : r_words_left[4:0];

    assign busy_out              = r_busy;
    assign write_done_out        = r_done;
    assign ddr3_emif_write       = r_write;
    assign ddr3_emif_read        = 1'b0;
    assign ddr3_emif_addr        = r_emif_addr;
    assign ddr3_emif_burst_count = r_burst_cnt;
    assign ddr3_emif_byte_enable = 32'hFFFF_FFFF;
    assign ddr3_emif_write_data  = (w_count == '0) ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge mem_clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data_in;
    end

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            r_state           <= S_IDLE;
            r_addr            <= '0;
            r_words_left      <= '0;
            r_words_to_accept <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_write           <= 1'b0;
            r_emif_addr       <= '0;
            r_burst_cnt       <= '0;
            r_beat            <= '0;
        end else begin
            if (w_push)
                r_words_to_accept <= r_words_to_accept - 32'd1;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_addr            <= start_addr_in;
                        r_words_left      <= to_write_word_in;
                        r_words_to_accept <= to_write_word_in;
                        r_busy            <= 1'b1;
                        r_state           <= (to_write_word_in == 32'd0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (32'(w_count) >= 32'(w_blen)) begin
                        r_emif_addr <= r_addr;
                        r_burst_cnt <= w_blen;
                        r_beat      <= '0;
                        r_write     <= 1'b1;
                        r_state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_pop) begin
                        r_beat <= r_beat + 5'd1;
                        if (r_beat == r_burst_cnt - 5'd1) begin
                            r_write      <= 1'b0;
                            r_addr       <= r_addr + 22'(r_burst_cnt);
                            r_words_left <= r_words_left - 32'(r_burst_cnt);
                            if (r_words_left == 32'(r_burst_cnt)) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_FILL;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // A zero-length request arrives here without the pulse raised yet.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// tb_ddr3_frame_writer: directed frames with hand-computed burst layouts; a
// negedge monitor checks every presented EMIF beat against a scoreboard queue.
module tb_ddr3_frame_writer;

    typedef struct {
        logic [21:0]  addr;
        logic [4:0]   cnt;
        logic [255:0] data;
        bit           last;
    } beat_t;

    logic         mem_clk;
    logic         mem_rst;
    logic         start_in;
    logic [21:0]  start_addr_in;
    logic [31:0]  to_write_word_in;
    logic         busy_out;
    logic         write_done_out;
    logic [255:0] wr_data_in;
    logic         wr_data_valid_in;
    logic         wr_ready_out;
    logic         ddr3_emif_ready;
    logic         ddr3_emif_write;
    logic         ddr3_emif_read;
    logic [21:0]  ddr3_emif_addr;
    logic [255:0] ddr3_emif_write_data;
    logic [31:0]  ddr3_emif_byte_enable;
    logic [4:0]   ddr3_emif_burst_count;

    int    vectors    = 0;
    int    errors     = 0;
    int    beatCount  = 0;
    int    doneCount  = 0;
    bit    midBurst   = 0;
    beat_t expq[$];
    beat_t monHead;
    logic [7:0] expTag;
    int    expIdx;

    ddr3_frame_writer dut (
        .mem_clk               (mem_clk),
        .mem_rst               (mem_rst),
        .start_in              (start_in),
        .start_addr_in         (start_addr_in),
        .to_write_word_in      (to_write_word_in),
        .busy_out              (busy_out),
        .write_done_out        (write_done_out),
        .wr_data_in            (wr_data_in),
        .wr_data_valid_in      (wr_data_valid_in),
        .wr_ready_out          (wr_ready_out),
        .ddr3_emif_ready       (ddr3_emif_ready),
        .ddr3_emif_write       (ddr3_emif_write),
        .ddr3_emif_read        (ddr3_emif_read),
        .ddr3_emif_addr        (ddr3_emif_addr),
        .ddr3_emif_write_data  (ddr3_emif_write_data),
        .ddr3_emif_byte_enable (ddr3_emif_byte_enable),
        .ddr3_emif_burst_count (ddr3_emif_burst_count)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    function automatic logic [255:0] wordOf(input logic [7:0] tag, input int i);
        logic [255:0] w;
        w = '0;
        for (int l = 0; l < 8; l++)
            w[32*l +: 32] = {tag, 8'(l), 16'(i)};
        return w;
    endfunction

    // Mode 1 is the repeating 1,0,0,1 ready pattern.
    function automatic logic readyPat(input int mode, input int c);
        if (mode == 0)
            return 1'b1;
        return !((c % 4 == 1) || (c % 4 == 2));
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic beginFrame(input logic [7:0] tag);
        expTag = tag;
        expIdx = 0;
    endtask

    task automatic expectBurst(input logic [21:0] a, input int n);
        beat_t b;
        for (int j = 0; j < n; j++) begin
            b.addr = a;
            b.cnt  = 5'(n);
            b.data = wordOf(expTag, expIdx);
            b.last = (j == n - 1);
            expq.push_back(b);
            expIdx++;
        end
    endtask

    always @(negedge mem_clk) begin
        if (mem_rst) begin
            midBurst = 0;
        end else begin
            if (midBurst)
                checkOutput("noGapInBurst", 256'(ddr3_emif_write), 256'd1);
            midBurst = 0;
            if (ddr3_emif_write) begin
                if (expq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got write at addr %0h, required no write", ddr3_emif_addr);
                end else begin
                    monHead = expq[0];
                    checkOutput("beatAddr", 256'(ddr3_emif_addr), 256'(monHead.addr));
                    checkOutput("beatCount", 256'(ddr3_emif_burst_count), 256'(monHead.cnt));
                    checkOutput("beatData", ddr3_emif_write_data, monHead.data);
                    if (ddr3_emif_ready) begin
                        void'(expq.pop_front());
                        beatCount++;
                        midBurst = !monHead.last;
                    end else begin
                        midBurst = 1;
                    end
                end
            end
            if (write_done_out) begin
                doneCount++;
                checkOutput("busyLowWithDone", 256'(busy_out), 256'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [21:0] addr, input int nWords, input int offered,
                                 input int readyMode, input int abortAfter, input logic [7:0] tag);
        int idx = 0;
        int it = 0;
        int post = 0;
        int doneBase;
        int beatBase;
        bit xfer;
        bit seenDone = 0;
        bit aborted = 0;
        doneBase = doneCount;
        beatBase = beatCount;
        @(posedge mem_clk); #1;
        start_in         = 1'b1;
        start_addr_in    = addr;
        to_write_word_in = 32'(nWords);
        wr_data_valid_in = (offered > 0);
        wr_data_in       = wordOf(tag, 0);
        ddr3_emif_ready  = readyPat(readyMode, 0);
        @(posedge mem_clk); #1;
        start_in = 1'b0;
        checkOutput("busyAfterStart", 256'(busy_out), 256'd1);
        checkOutput("readyAfterStart", 256'(wr_ready_out), 256'(nWords != 0));
        checkOutput("noEarlyDone", 256'(write_done_out), 256'd0);
        while (it < 600 && post < 5 && !aborted) begin
            @(negedge mem_clk);
            xfer = wr_data_valid_in && wr_ready_out;
            @(posedge mem_clk); #1;
            if (xfer)
                idx++;
            if (nWords == 0 && it == 0)
                checkOutput("zeroLenDoneAt2", 256'(write_done_out), 256'd1);
            wr_data_valid_in = (idx < offered);
            wr_data_in       = wordOf(tag, idx);
            ddr3_emif_ready  = readyPat(readyMode, it + 1);
            if (doneCount != doneBase)
                seenDone = 1;
            if (seenDone)
                post++;
            if (abortAfter > 0 && beatCount - beatBase >= abortAfter) begin
                mem_rst = 1'b1;
                #1;
                checkOutput("rstWrite", 256'(ddr3_emif_write), 256'd0);
                checkOutput("rstBusy", 256'(busy_out), 256'd0);
                checkOutput("rstReady", 256'(wr_ready_out), 256'd0);
                checkOutput("rstData", ddr3_emif_write_data, 256'd0);
                checkOutput("rstAddr", 256'(ddr3_emif_addr), 256'd0);
                expq.delete();
                wr_data_valid_in = 1'b0;
                @(posedge mem_clk); #1;
                mem_rst = 1'b0;
                aborted = 1;
            end
            it++;
        end
        if (!aborted) begin
            checkOutput("frameCompleted", 256'(seenDone), 256'd1);
            checkOutput("wordsAccepted", 256'(idx), 256'(nWords));
            checkOutput("donePulses", 256'(doneCount - doneBase), 256'd1);
            checkOutput("beatsOutstanding", 256'(expq.size()), 256'd0);
        end
        wr_data_valid_in = 1'b0;
        ddr3_emif_ready  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem_rst          = 1'b1;
        start_in         = 1'b0;
        start_addr_in    = '0;
        to_write_word_in = '0;
        wr_data_in       = '0;
        wr_data_valid_in = 1'b0;
        ddr3_emif_ready  = 1'b1;
        repeat (3) @(posedge mem_clk);
        #1;
        checkOutput("resetBusy", 256'(busy_out), 256'd0);
        checkOutput("resetDone", 256'(write_done_out), 256'd0);
        checkOutput("resetReady", 256'(wr_ready_out), 256'd0);
        checkOutput("resetWrite", 256'(ddr3_emif_write), 256'd0);
        checkOutput("resetRead", 256'(ddr3_emif_read), 256'd0);
        checkOutput("resetAddr", 256'(ddr3_emif_addr), 256'd0);
        checkOutput("resetBurstCount", 256'(ddr3_emif_burst_count), 256'd0);
        checkOutput("resetData", ddr3_emif_write_data, 256'd0);
        checkOutput("resetByteEnable", 256'(ddr3_emif_byte_enable), 256'hFFFF_FFFF);
        mem_rst = 1'b0;

        $display("[TB] single burst");
        beginFrame(8'h11);
        expectBurst(22'h000100, 8);
        applyStimulus(22'h000100, 8, 8, 0, 0, 8'h11);

        $display("[TB] short final burst");
        beginFrame(8'h22);
        expectBurst(22'h001000, 8);
        expectBurst(22'h001008, 8);
        expectBurst(22'h001010, 4);
        applyStimulus(22'h001000, 20, 20, 0, 0, 8'h22);

        $display("[TB] emif back-pressure");
        beginFrame(8'h33);
        expectBurst(22'h000040, 8);
        applyStimulus(22'h000040, 8, 8, 1, 0, 8'h33);

        $display("[TB] zero length");
        applyStimulus(22'h000500, 0, 4, 0, 0, 8'h44);

        $display("[TB] over-supply and wrap");
        beginFrame(8'h55);
        expectBurst(22'h3FFFF8, 8);
        expectBurst(22'h000000, 4);
        applyStimulus(22'h3FFFF8, 12, 16, 0, 0, 8'h55);

        $display("[TB] reset mid-burst");
        beginFrame(8'h66);
        expectBurst(22'h000300, 8);
        applyStimulus(22'h000300, 8, 8, 0, 3, 8'h66);
        beginFrame(8'h77);
        expectBurst(22'h000200, 8);
        applyStimulus(22'h000200, 8, 8, 0, 0, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
